// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start, data, optional parity and stop bits
// against an external edge/bit counter and issues sampler, shift and checker strobes.
module uart_rx_fsm #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned B_C_W      = $clog2(Data_Width + 4)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic [5:0]       Prescale,
    input  logic [5:0]       Edge_Count,
    input  logic [B_C_W-1:0] Bit_Count,
    input  logic             Strt_Glitch,
    input  logic             Par_Err,
    input  logic             Stp_Err,
    output logic             Cnt_En,
    output logic             Dat_Samp_En,
    output logic             Deser_En,
    output logic             Strt_Chk_En,
    output logic             Par_Chk_En,
    output logic             Stp_Chk_En,
    output logic             Data_Valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   err_flag, err_nxt, dv_nxt;
    logic   at_cp, at_eob, last_data;

    // Check point sits just past mid-bit; end of bit is the last oversample edge.
    assign at_cp     = (Edge_Count == ((Prescale >> 1) + 6'd1));
    assign at_eob    = (Edge_Count == (Prescale - 6'd1));
    assign last_data = (Bit_Count == B_C_W'(Data_Width));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            err_flag   <= 1'b0;
            Data_Valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_flag   <= err_nxt;
            Data_Valid <= dv_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        err_nxt     = err_flag;
        dv_nxt      = 1'b0;
        Cnt_En      = 1'b1;
        Dat_Samp_En = 1'b1;
        Deser_En    = 1'b0;
        Strt_Chk_En = 1'b0;
        Par_Chk_En  = 1'b0;
        Stp_Chk_En  = 1'b0;

        case (state)
            IDLE: begin
                Cnt_En      = 1'b0;
                Dat_Samp_En = 1'b0;
                if (!RX_IN) begin
                    state_nxt = START;
                    err_nxt   = 1'b0;
                end
            end
            START: begin
                Strt_Chk_En = at_cp;
                if (at_cp && Strt_Glitch) begin
                    state_nxt = IDLE;
                end else if (at_eob) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                Deser_En = at_cp;
                if (at_eob && last_data) begin
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                Par_Chk_En = at_cp;
                if (at_cp && Par_Err) begin
                    err_nxt = 1'b1;
                end
                if (at_eob) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                Stp_Chk_En = at_cp;
                if (at_cp && Stp_Err) begin
                    err_nxt = 1'b1;
                end
                // Errors never abort: the stop bit always runs to its end.
                if (at_eob) begin
                    state_nxt = IDLE;
                    dv_nxt    = !err_nxt;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: Data_Width, default 8, number of data bits per frame.
REQ-002 Parameter: B_C_W, default $clog2(Data_Width+4), width of the Bit_Count input.
REQ-003 Port: CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-low.
REQ-005 Port: RX_IN  input  1  serial line; idle high, start bit low.
REQ-006 Port: PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 Port: Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-008 Port: Edge_Count  input  6  from the edge/bit counter; 0..Prescale-1 within a bit.
REQ-009 Port: Bit_Count  input  B_C_W  from the edge/bit counter; 0 = start bit, 1..Data_Width = data bits, then parity and stop.
REQ-010 Port: Strt_Glitch  input  1  start checker result; valid while Strt_Chk_En=1.
REQ-011 Port: Par_Err  input  1  parity checker result; valid while Par_Chk_En=1.
REQ-012 Port: Stp_Err  input  1  stop checker result; valid while Stp_Chk_En=1.
REQ-013 Port: Cnt_En  output  1  enable for the edge/bit counter.
REQ-014 Port: Dat_Samp_En  output  1  enable for the oversampling data sampler.
REQ-015 Port: Deser_En  output  1  one-cycle shift strobe for the deserializer.
REQ-016 Port: Strt_Chk_En, Par_Chk_En, Stp_Chk_En  output  1 each  one-cycle checker strobes.
REQ-017 Port: Data_Valid  output  1  one-cycle pulse marking a good frame.

Function
REQ-018 The state register SHALL hold one of five states: IDLE, START, DATA, PARITY, STOP.
REQ-019 Definitions: CP = Prescale/2 + 1 (the check point); EOB (end of bit) = Edge_Count == Prescale-1.
REQ-020 Cnt_En and Dat_Samp_En SHALL be 1 in every state except IDLE, where both are 0; they are decoded combinationally from the state.
REQ-021 IDLE -> START on the first clock where RX_IN=0; otherwise stay in IDLE.
REQ-022 Because Cnt_En is 0 in IDLE, the counter is clear on entry, so Edge_Count=0 and Bit_Count=0 in the first START cycle.
REQ-023 START: Strt_Chk_En=1 while Edge_Count==CP.
- If Strt_Glitch=1 in that cycle, next state is IDLE.
- Otherwise START -> DATA at EOB.
REQ-024 DATA: Deser_En=1 while Edge_Count==CP, giving exactly Data_Width strobes per frame.
- At EOB with Bit_Count==Data_Width: next state is PARITY if PAR_EN=1, else STOP.
REQ-025 PARITY: Par_Chk_En=1 while Edge_Count==CP.
- Par_Err=1 in that cycle sets an internal sticky error flag.
- PARITY -> STOP at EOB.
REQ-026 STOP: Stp_Chk_En=1 while Edge_Count==CP.
- Stp_Err=1 in that cycle sets the error flag.
- STOP -> IDLE at EOB.
REQ-027 Data_Valid SHALL be a registered pulse, 1 for exactly the cycle after the STOP EOB cycle, and only if the error flag is 0.
REQ-028 The error flag SHALL clear on IDLE -> START.
REQ-029 A parity or stop error SHALL NOT abort the frame; the FSM always completes the stop bit before returning to IDLE.
REQ-030 Back-to-back frames: the FSM passes through at least one IDLE cycle between frames, so the counter clears. A start bit beginning in the cycle after STOP EOB is accepted from that IDLE cycle.
REQ-031 A start glitch SHALL produce no Deser_En, Data_Valid or further check strobes for that frame.
REQ-032 Prescale and PAR_EN are sampled only by the behaviour above and SHALL be held stable outside IDLE; behaviour for illegal Prescale values is unspecified.
REQ-033 All strobes (Deser_En and the three check enables) SHALL be 0 in IDLE and at most one cycle wide per bit.

Reset
REQ-034 RST=0 SHALL asynchronously force IDLE, clear the error flag and the Data_Valid register, and drive every output to 0. This holds at any point, including mid-frame.
REQ-035 After RST deasserts, the FSM SHALL need a fresh RX_IN falling level in IDLE to start a frame.

Verification
REQ-036 Good frame: Prescale=8, PAR_EN=0, data 0xA5 LSB first, RX_IN low at cycle 0 in IDLE -> START cycles 1-8, eight Deser_En pulses at Edge_Count=5, STOP cycles 73-80, Data_Valid=1 only at cycle 81.
REQ-037 Parity frame: Prescale=8, PAR_EN=1, Par_Err=0 -> one Par_Chk_En, Data_Valid only at cycle 89; repeat with Par_Err=1 at the strobe -> no Data_Valid, IDLE at cycle 89.
REQ-038 Start glitch: RX_IN low for 3 cycles, Strt_Glitch=1 at Strt_Chk_En -> IDLE the next cycle, Cnt_En=0, no Deser_En.
REQ-039 Stop error: Stp_Err=1 at Stp_Chk_En -> STOP completes to EOB, no Data_Valid; the next good frame yields Data_Valid (error flag cleared).
REQ-040 Back-to-back: second start bit immediately after the first stop -> exactly one IDLE cycle, two Data_Valid pulses 81 cycles apart (Prescale=8, PAR_EN=0).
REQ-041 Reset mid-DATA: RST=0 at cycle 40 -> all outputs 0 in the same cycle, IDLE held, no Data_Valid for the aborted frame.
